// File: rtl/sobel_mem_sequencer.sv
// Walks the interior of a grayscale frame, gathers each 3x3 neighbourhood through the
// Avalon master FSM, hands the window to the Sobel stage and writes the magnitude back.
module sobel_mem_sequencer #(
  parameter int          IMG_W    = 8,
  parameter int          IMG_H    = 8,
  parameter logic [31:0] SRC_BASE = 32'h0000_0000,
  parameter logic [31:0] DST_BASE = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        readen,
  output logic        writen,
  output logic [31:0] inaddr,
  output logic [31:0] wdata,
  input  logic        dataready,
  input  logic [31:0] readdata,
  output logic        win_valid,
  output logic [71:0] window,
  input  logic        result_valid,
  input  logic [7:0]  result
);

  typedef enum logic [3:0] {
    IDLE, RD_REQ, RD_WAIT, WIN_OUT, RES_WAIT, WR_REQ, WR_WAIT, NEXT, DONE
  } state_t;

  state_t      state, state_d;
  logic [15:0] x, x_d, y, y_d;
  logic [3:0]  k, k_d;
  logic        wcnt, wcnt_d;
  logic [71:0] win_d;
  logic [31:0] addr_d, wdata_d;
  logic        unused_hi;

  assign unused_hi = ^readdata[31:8];

  function automatic logic [31:0] pix_addr(input logic [31:0] base, input logic [15:0] px,
                                           input logic [15:0] py);
    return base + ((32'(py) * 32'(IMG_W) + 32'(px)) << 2);
  endfunction

  // Slot kk maps to dx = kk%3 - 1, dy = kk/3 - 1 around (px,py).
  function automatic logic [31:0] nbr_addr(input logic [15:0] px, input logic [15:0] py,
                                           input logic [3:0] kk);
    logic [15:0] nx, ny;
    case (kk)
      4'd0, 4'd3, 4'd6: nx = px - 16'd1;
      4'd1, 4'd4, 4'd7: nx = px;
      default:          nx = px + 16'd1;
    endcase
    if (kk < 4'd3)      ny = py - 16'd1;
    else if (kk < 4'd6) ny = py;
    else                ny = py + 16'd1;
    return pix_addr(SRC_BASE, nx, ny);
  endfunction

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state  <= IDLE;
      x      <= '0;
      y      <= '0;
      k      <= '0;
      wcnt   <= 1'b0;
      window <= '0;
      inaddr <= '0;
      wdata  <= '0;
    end else begin
      state  <= state_d;
      x      <= x_d;
      y      <= y_d;
      k      <= k_d;
      wcnt   <= wcnt_d;
      window <= win_d;
      inaddr <= addr_d;
      wdata  <= wdata_d;
    end
  end

  // inaddr/wdata are loaded with the value for the state being entered, so the
  // registered bus is already valid in the request cycle and held until completion.
  always_comb begin
    state_d = state;
    x_d     = x;
    y_d     = y;
    k_d     = k;
    wcnt_d  = wcnt;
    win_d   = window;
    addr_d  = '0;
    wdata_d = '0;
    case (state)
      IDLE: if (start) begin
        x_d     = 16'd1;
        y_d     = 16'd1;
        k_d     = 4'd0;
        addr_d  = nbr_addr(16'd1, 16'd1, 4'd0);
        state_d = RD_REQ;
      end
      RD_REQ: begin
        addr_d  = inaddr;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        addr_d = inaddr;
        if (dataready) begin
          for (int i = 0; i < 9; i++)
            if (4'(i) == k) win_d[8*i +: 8] = readdata[7:0];
          if (k == 4'd8) begin
            addr_d  = '0;
            state_d = WIN_OUT;
          end else begin
            k_d     = k + 4'd1;
            addr_d  = nbr_addr(x, y, k + 4'd1);
            state_d = RD_REQ;
          end
        end
      end
      WIN_OUT: state_d = RES_WAIT;
      RES_WAIT: if (result_valid) begin
        addr_d  = pix_addr(DST_BASE, x, y);
        wdata_d = {24'b0, result};
        state_d = WR_REQ;
      end
      WR_REQ: begin
        addr_d  = inaddr;
        wdata_d = wdata;
        wcnt_d  = 1'b0;
        state_d = WR_WAIT;
      end
      WR_WAIT: begin
        addr_d  = inaddr;
        wdata_d = wdata;
        wcnt_d  = 1'b1;
        if (wcnt) begin
          addr_d  = '0;
          wdata_d = '0;
          state_d = NEXT;
        end
      end
      NEXT: begin
        k_d = 4'd0;
        if (x < 16'(IMG_W - 2)) begin
          x_d = x + 16'd1;
        end else begin
          x_d = 16'd1;
          y_d = y + 16'd1;
        end
        if (x == 16'(IMG_W - 2) && y == 16'(IMG_H - 2)) begin
          state_d = DONE;
        end else begin
          addr_d  = nbr_addr(x_d, y_d, 4'd0);
          state_d = RD_REQ;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign readen    = (state == RD_REQ);
  assign writen    = (state == WR_REQ);
  assign win_valid = (state == WIN_OUT);

endmodule
